// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter
//   Round-robin arbiter in front of one data-memory bank. Each cycle it picks at
//   most one requester and drives the bank pins from registers. One cycle later
//   it returns a response pulse to that requester, with the read data when the
//   access was a read.
//
// Ports
//   clk_i, rst_ni       system clock (rising edge), async active-low reset
//   req_i/wr_i          per-requester request level / write(1) or read(0)
//   addr_i/wdata_i      packed per-requester address and write data
//   gnt_o               one-hot grant, high in the cycle the access is on the bank
//   rsp_valid_o         one-hot completion pulse, one cycle after gnt_o
//   rsp_data_o          data from the most recent completed read
//   mem_*_o             registered bank pins (Address/WriteData/MemWrite/MemRead)
//   mem_read_data_i     bank ReadData (combinational, valid while mem_read_o)
//
// state | meaning
// IDLE  | no access on the bank this cycle
// ISSUE | one registered access is on the bank this cycle
module mem_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  wr_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  rsp_valid_o,
  output logic [DW-1:0]    rsp_data_o,
  output logic [AW-1:0]    mem_address_o,
  output logic [DW-1:0]    mem_write_data_o,
  output logic             mem_write_o,
  output logic             mem_read_o,
  input  logic [DW-1:0]    mem_read_data_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [PW-1:0]     win;
  logic [AW-1:0]     addr_arr [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*AW +: AW];
    assign wdata_arr[g] = wdata_i[g*DW +: DW];
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // Next state: round-robin search starting at ptr_q. The requester being
  // granted right now still holds its Req, so it is masked out; a held Req
  // becomes eligible again at the following edge.
  always_comb begin
    eligible = req_i & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      logic [PW-1:0] idx_p;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PW'(idx);
      if (!found && eligible[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
    state_d = found ? ISSUE : IDLE;
    ptr_d   = ptr_q;
    if (found) ptr_d = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
  end

  // Outputs: next values of the registered pins and the response path
  always_comb begin
    gnt_d       = '0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == ISSUE) begin
      gnt_d[win]  = 1'b1;
      mem_addr_d  = addr_arr[win];
      mem_wdata_d = wdata_arr[win];
      mem_write_d = wr_i[win];
      mem_read_d  = ~wr_i[win];
    end
    rsp_valid_d = gnt_q;
    // Bank read data is valid during the ISSUE cycle; capture it as that
    // cycle ends. Writes leave the last read data in place.
    rsp_data_d  = (state_q == ISSUE && mem_read_q) ? mem_read_data_i : rsp_data_q;
  end

  assign gnt_o            = gnt_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign mem_address_o    = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;
  assign mem_write_o      = mem_write_q;
  assign mem_read_o       = mem_read_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter
//   Drives mem_bank_arbiter (NREQ=4, AW=DW=8) with a 256x8 bank behind it.
//   Directed vectors plus randomized requesters are compared against a
//   cycle-level reference model built from the arbitration rules.
module tb_mem_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bank_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .wr_i             (wr),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .gnt_o            (gnt),
    .rsp_valid_o      (rsp_valid),
    .rsp_data_o       (rsp_data),
    .mem_address_o    (mem_addr),
    .mem_write_data_o (mem_wdata),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_read_data_i  (mem_rdata)
  );

  // Bank behind the arbiter
  logic [7:0] bank [256] = '{default: 8'h00};
  always @(posedge clk) if (mem_write) bank[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? bank[mem_addr] : 8'h00;

  // Reference model
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  int         m_ptr;
  logic [3:0] m_gnt, m_rv;
  logic [7:0] m_rd, m_ma, m_md;
  logic       m_mw, m_mr;

  task automatic model_reset();
    m_ptr = 0; m_gnt = 4'h0; m_rv = 4'h0; m_rd = 8'h00;
    m_ma = 8'h00; m_md = 8'h00; m_mw = 1'b0; m_mr = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] elig;
    int w;
    m_rv = m_gnt;
    if (m_mr) m_rd = ref_mem[m_ma];
    if (m_mw) ref_mem[m_ma] = m_md;
    elig = req & ~m_gnt;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (w < 0 && elig[j[1:0]]) w = j;
    end
    if (w >= 0) begin
      m_gnt = 4'b0001 << w;
      m_ma  = addr[w*8 +: 8];
      m_md  = wdata[w*8 +: 8];
      m_mw  = wr[w[1:0]];
      m_mr  = !wr[w[1:0]];
      m_ptr = (w + 1) % 4;
    end else begin
      m_gnt = 4'h0; m_mw = 1'b0; m_mr = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("model_rsp_data", 32'(rsp_data), 32'(m_rd));
    chk("model_mem_write", 32'(mem_write), 32'(m_mw));
    chk("model_mem_read", 32'(mem_read), 32'(m_mr));
    chk("model_mem_addr", 32'(mem_addr), 32'(m_ma));
    chk("model_mem_wdata", 32'(mem_wdata), 32'(m_md));
  endtask

  // Called at/after a negedge: drive, let one edge happen, check at negedge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [3:0]  req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  e_gnt, e_rv;
    logic [7:0]  e_rd;
    logic        e_mw, e_mr;
    logic [7:0]  e_ma;
  } vec_t;

  vec_t vt [15];

  logic       p_req [4];
  logic       p_wr  [4];
  logic [7:0] p_addr[4];
  logic [7:0] p_wd  [4];
  int         wc    [4];
  int         maxw;
  int         diffs;

  initial begin
    // contention (reads, ptr starts at 0)
    vt[0]  = '{4'b1111, 4'b0000, 32'h23222120, 32'h0, 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h20};
    vt[1]  = '{4'b1111, 4'b0000, 32'h23222120, 32'h0, 4'b0010, 4'b0001, 8'h00, 1'b0, 1'b1, 8'h21};
    vt[2]  = '{4'b1111, 4'b0000, 32'h23222120, 32'h0, 4'b0100, 4'b0010, 8'h00, 1'b0, 1'b1, 8'h22};
    vt[3]  = '{4'b1111, 4'b0000, 32'h23222120, 32'h0, 4'b1000, 4'b0100, 8'h00, 1'b0, 1'b1, 8'h23};
    vt[4]  = '{4'b0000, 4'b0000, 32'h23222120, 32'h0, 4'b0000, 4'b1000, 8'h00, 1'b0, 1'b0, 8'h23};
    // pointer wrapped to 0: req1 before req3
    vt[5]  = '{4'b1010, 4'b0000, 32'h23222120, 32'h0, 4'b0010, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h21};
    vt[6]  = '{4'b1010, 4'b0000, 32'h23222120, 32'h0, 4'b1000, 4'b0010, 8'h00, 1'b0, 1'b1, 8'h23};
    vt[7]  = '{4'b0000, 4'b0000, 32'h23222120, 32'h0, 4'b0000, 4'b1000, 8'h00, 1'b0, 1'b0, 8'h23};
    // req0 writes 0x5A to 0x10, then reads it back
    vt[8]  = '{4'b0001, 4'b0001, 32'h00000010, 32'h0000005A, 4'b0001, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h10};
    vt[9]  = '{4'b0000, 4'b0000, 32'h00000010, 32'h0000005A, 4'b0000, 4'b0001, 8'h00, 1'b0, 1'b0, 8'h10};
    vt[10] = '{4'b0001, 4'b0000, 32'h00000010, 32'h0,        4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h10};
    vt[11] = '{4'b0000, 4'b0000, 32'h00000010, 32'h0,        4'b0000, 4'b0001, 8'h5A, 1'b0, 1'b0, 8'h10};
    // req2 writes 0xC3 to 0xFF, req1 reads 0xFF next issue cycle
    vt[12] = '{4'b0100, 4'b0100, 32'h00FF0000, 32'h00C30000, 4'b0100, 4'b0000, 8'h5A, 1'b1, 1'b0, 8'hFF};
    vt[13] = '{4'b0010, 4'b0000, 32'h0000FF00, 32'h0,        4'b0010, 4'b0100, 8'h5A, 1'b0, 1'b1, 8'hFF};
    vt[14] = '{4'b0000, 4'b0000, 32'h0,        32'h0,        4'b0000, 4'b0010, 8'hC3, 1'b0, 1'b0, 8'hFF};

    // Reset with random inputs
    rst_n = 1'b0;
    req = 4'($urandom); wr = 4'($urandom); addr = $urandom; wdata = $urandom;
    model_reset();
    #23;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(4'h0, 4'h0, 32'h0, 32'h0);
      chk("idle_mem_write", 32'(mem_write), 32'h0);
      chk("idle_mem_read", 32'(mem_read), 32'h0);
    end

    // Directed table
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].req, vt[i].wr, vt[i].addr, vt[i].wdata);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vt[i].e_mw));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vt[i].e_mr));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_ma));
    end

    // Reset during a write cycle to 0xFF: must not commit or respond
    cycle(4'b0100, 4'b0100, 32'h00FF0000, 32'h00770000);
    chk("mid_gnt", 32'(gnt), 32'h4);
    chk("mid_mem_write", 32'(mem_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_write", 32'(mem_write), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(4'h0, 4'h0, 32'h0, 32'h0);
    chk("mid_after_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_bank_ff", 32'(bank[8'hFF]), 32'hC3);

    // Randomized requesters obeying the hold-until-granted rule
    for (int i = 0; i < 4; i++) begin
      p_req[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = 8'h0; p_wd[i] = 8'h0; wc[i] = 0;
    end
    maxw = 0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  rq, wq;
      logic [31:0] aq, dq;
      for (int i = 0; i < 4; i++) begin
        if (p_req[i] && m_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) p_req[i] = 1'b0;
          else begin
            p_wr[i] = 1'($urandom_range(1, 0));
            p_addr[i] = 8'($urandom_range(7, 0));
            p_wd[i] = 8'($urandom_range(255, 0));
          end
        end else if (!p_req[i] && $urandom_range(99, 0) < 35) begin
          p_req[i] = 1'b1;
          p_wr[i] = 1'($urandom_range(1, 0));
          p_addr[i] = 8'($urandom_range(7, 0));
          p_wd[i] = 8'($urandom_range(255, 0));
        end
        rq[i] = p_req[i];
        wq[i] = p_wr[i];
        aq[i*8 +: 8] = p_addr[i];
        dq[i*8 +: 8] = p_wd[i];
      end
      cycle(rq, wq, aq, dq);
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && !gnt[i]) wc[i]++;
        else wc[i] = 0;
        if (wc[i] > maxw) maxw = wc[i];
      end
    end
    chk("max_wait_le_nreq", 32'(maxw <= 4), 32'h1);

    cycle(4'h0, 4'h0, 32'h0, 32'h0);
    cycle(4'h0, 4'h0, 32'h0, 32'h0);
    diffs = 0;
    for (int a = 0; a < 256; a++) if (bank[a] !== ref_mem[a]) diffs++;
    chk("bank_contents_diffs", 32'(diffs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Round-robin arbiter that shares one 256x8 data-memory bank among NREQ requesters (processing elements or DMA ports) in the multi-bank data-memory subsystem. It accepts per-requester read/write commands, grants one per cycle, drives the bank's Address/WriteData/MemWrite/MemRead pins from registers, and returns a one-cycle response pulse with captured read data. One instance sits in front of each bank.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 8: address width
- DW, 8: data width
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset; asynchronous, active-low
- Req  in  NREQ  per-requester access request, level, held until granted
- Wr  in  NREQ  per-requester command: 1 = write, 0 = read
- Addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- WData  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- Gnt  out  NREQ  one-hot grant, high during the cycle the access is issued
- RspValid  out  NREQ  one-hot, one-cycle pulse when requester's access has completed
- RspData  out  DW  read data of the most recent completed read
- MemAddress  out  AW  to bank Address
- MemWriteData  out  DW  to bank WriteData
- MemWrite  out  1  to bank MemWrite
- MemRead  out  1  to bank MemRead
- MemReadData  in  DW  from bank ReadData (combinational; 0 when MemRead=0)

## Operation
- States: IDLE (no access on bank), ISSUE (one registered access on bank this cycle).
- Arbitration at every rising edge over eligible = Req & ~Gnt (requester currently granted is masked, since its Req is still high while it observes Gnt).
- Round-robin: search starts at index ptr, wraps modulo NREQ; first eligible wins. After a win, ptr <= winner+1 (wrap to 0 at NREQ). Reset ptr = 0, so requester 0 highest priority first.
- Eligible nonzero: next state ISSUE; register winner's Addr/WData/Wr into MemAddress/MemWriteData, MemWrite = Wr, MemRead = ~Wr, Gnt = one-hot(winner).
- Eligible zero: next state IDLE; Gnt = 0, MemWrite = MemRead = 0; MemAddress/MemWriteData hold previous value.
- ISSUE -> ISSUE allowed back-to-back (full throughput, one access per cycle when different requesters contend).
- Completion: at the edge ending an ISSUE cycle, RspValid = Gnt (pulses for both reads and writes); if the access was a read, RspData <= MemReadData; for a write, RspData holds.
- Requester rule: Addr/Wr/WData stable from Req rise until Gnt observed; may change or drop Req after the Gnt cycle. Keeping Req high requests a further access, considered no earlier than the following edge.
- Bank write commits at the edge ending ISSUE; a read of the same address issued in the next cycle returns the new data.
- No starvation: any requester holding Req is granted within NREQ issue cycles.

## Timing
- Reset (Rst=0, async): state IDLE, ptr 0, Gnt 0, RspValid 0, RspData 0, MemAddress 0, MemWriteData 0, MemWrite 0, MemRead 0. Memory contents are not affected.
- Reset mid-access: MemWrite/MemRead drop immediately; in-flight write aborted (not committed unless the edge already occurred); no RspValid for it.
- Latency: Req high before edge k -> Gnt and bank pins active in cycle k..k+1 -> RspValid/RspData valid in cycle after (2 edges from request sample to response).
- All outputs registered; no combinational path from Req/Addr/WData to any output.

## Test plan
- Reset: Rst=0 with random inputs -> all outputs 0; release, Req=0 -> stays IDLE, MemRead=MemWrite=0.
- Single write then read: req0 writes 0x5A to 0x10 -> Gnt=0001, MemWrite=1, MemAddress=0x10 for one cycle, RspValid=0001 next; req0 reads 0x10 -> RspData=0x5A with RspValid=0001.
- Full contention: Req=1111 held constantly, NREQ=4 -> Gnt sequence 0001,0010,0100,1000,0001..., one grant per cycle, no gaps.
- Pointer wrap: after req3 wins, only req1 and req3 requesting -> req1 granted before req3.
- Read-after-write: req2 writes 0xC3 to 0xFF, req1 reads 0xFF in the next issue cycle -> RspData=0xC3, RspValid=0010.
- Reset mid-ISSUE: assert Rst during a write cycle before its edge -> MemWrite falls immediately, location 0xFF keeps old value, no RspValid.
